ramb4_s4_arb: RTL

RAMB4_S4_ARB -- requirements
Module: ramb4_s4_arb

---
 rtl/ramb4_s4_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ramb4_s4_arb.sv
// Two-requester round-robin arbiter in front of one RAMB4 (1024x4) port.
// Optional RAMB4_ARB_LOCK_EN adds LOCK0/LOCK1 so an owner can keep the port.
module ramb4_s4_arb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DI0,
  input  logic [DATA_W-1:0] DI1,
`ifdef RAMB4_ARB_LOCK_EN
  input  logic              LOCK0,
  input  logic              LOCK1,
`endif
  output logic              GNT0,
  output logic              GNT1,
  output logic [DATA_W-1:0] DO0,
  output logic [DATA_W-1:0] DO1,
  output logic              VLD0,
  output logic              VLD1,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DI,
  input  logic [DATA_W-1:0] RAM_DO
);

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_P0   = 2'd1,
    ST_P1   = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   vld0_q, vld0_d;
  logic   vld1_q, vld1_d;
  logic   lock0, lock1;
  logic   xfer0, xfer1;

`ifdef RAMB4_ARB_LOCK_EN
  assign lock0 = LOCK0;
  assign lock1 = LOCK1;
`else
  assign lock0 = 1'b0;
  assign lock1 = 1'b0;
`endif

  assign xfer0 = (state_q == ST_P0) & REQ0;
  assign xfer1 = (state_q == ST_P1) & REQ1;

  // prio_q = 0 favours requester 0 on a simultaneous request from idle
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    vld0_d  = xfer0 & ~WE0;
    vld1_d  = xfer1 & ~WE1;
    if (xfer0) begin
      prio_d = 1'b1;
    end else if (xfer1) begin
      prio_d = 1'b0;
    end
    unique case (state_q)
      ST_NONE: begin
        if (REQ0 & REQ1) begin
          state_d = prio_q ? ST_P1 : ST_P0;
        end else if (REQ0) begin
          state_d = ST_P0;
        end else if (REQ1) begin
          state_d = ST_P1;
        end
      end
      ST_P0: begin
        if (REQ1 & ~(REQ0 & lock0)) begin
          state_d = ST_P1;
        end else if (!REQ0) begin
          state_d = ST_NONE;
        end
      end
      ST_P1: begin
        if (REQ0 & ~(REQ1 & lock1)) begin
          state_d = ST_P0;
        end else if (!REQ1) begin
          state_d = ST_NONE;
        end
      end
      default: state_d = ST_NONE;
    endcase
  end

  always_comb begin
    RAM_EN   = 1'b0;
    RAM_WE   = 1'b0;
    RAM_ADDR = '0;
    RAM_DI   = '0;
    unique case (state_q)
      ST_P0: begin
        RAM_EN   = REQ0;
        RAM_WE   = REQ0 & WE0;
        RAM_ADDR = ADDR0;
        RAM_DI   = DI0;
      end
      ST_P1: begin
        RAM_EN   = REQ1;
        RAM_WE   = REQ1 & WE1;
        RAM_ADDR = ADDR1;
        RAM_DI   = DI1;
      end
      default: begin
        RAM_EN = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_NONE;
      prio_q  <= 1'b0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
    end
  end

  assign GNT0 = (state_q == ST_P0);
  assign GNT1 = (state_q == ST_P1);
  assign VLD0 = vld0_q;
  assign VLD1 = vld1_q;
  assign DO0  = RAM_DO;
  assign DO1  = RAM_DO;

endmodule
